// File: rtl/adc_capture_ctrl_if.sv
// Sample stream from the adc block (data_out/data_valid) into the capture controller.
interface adc_capture_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Triggered acquisition controller: arm, wait for level-crossing trigger or timeout, store a record.
// Optional decimation of captured samples is enabled with `define ADC_CAPTURE_DECIM_EN.
module adc_capture_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    adc_capture_ctrl_if.slave       smp,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    trig_mode_i,
    input  logic [DATA_W-1:0]       trig_level_i,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [3:0]              decim_i,
`endif
    input  logic [DEPTH_LOG2-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timed_out_o,
    output logic [DEPTH_LOG2:0]     wr_count_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int unsigned       DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned       TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT);
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [1:0]              state_q, state_d;
    logic [DEPTH_LOG2:0]     wr_count_q, wr_count_d;
    logic                    timed_out_q, timed_out_d;
    logic [DATA_W-1:0]       prev_q, prev_d;
    logic                    prev_vld_q, prev_vld_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0]       rd_data_q;
    logic                    we;
    logic [DEPTH_LOG2-1:0]   waddr;
    logic                    edge_hit;
    logic                    to_hit;
    logic                    keep;
    logic [DATA_W-1:0]       mem [DEPTH];

`ifdef ADC_CAPTURE_DECIM_EN
    logic [3:0]              dec_cnt_q, dec_cnt_d;
`endif

    assign edge_hit = prev_vld_q && (prev_q < trig_level_i) && (smp.data >= trig_level_i);
    assign to_hit   = (TIMEOUT != 0) && (to_cnt_q == TO_MAX);

    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        timed_out_d = timed_out_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        to_cnt_d    = to_cnt_q;
        we          = 1'b0;
        waddr       = wr_count_q[DEPTH_LOG2-1:0];
`ifdef ADC_CAPTURE_DECIM_EN
        dec_cnt_d   = dec_cnt_q;
        keep        = (dec_cnt_q == decim_i);
`else
        keep        = 1'b1;
`endif
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d     = S_ARMED;
                        wr_count_d  = '0;
                        timed_out_d = 1'b0;
                        prev_vld_d  = 1'b0;
                        to_cnt_d    = '0;
                    end
                end
                S_ARMED: begin
                    if (smp.valid) begin
                        prev_d     = smp.data;
                        prev_vld_d = 1'b1;
                        if (!trig_mode_i || edge_hit || to_hit) begin
                            we          = 1'b1;
                            waddr       = '0;
                            wr_count_d  = (DEPTH_LOG2 + 1)'(1);
                            timed_out_d = to_hit;
                            state_d     = S_CAPTURE;
`ifdef ADC_CAPTURE_DECIM_EN
                            dec_cnt_d   = '0;
`endif
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                end
                S_CAPTURE: begin
                    if (smp.valid) begin
`ifdef ADC_CAPTURE_DECIM_EN
                        // Decimation phase counts every valid sample; only phase matches are stored.
                        dec_cnt_d = keep ? 4'd0 : dec_cnt_q + 4'd1;
`endif
                        if (keep) begin
                            we         = 1'b1;
                            wr_count_d = wr_count_q + (DEPTH_LOG2 + 1)'(1);
                            if (wr_count_d == FULL) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_count_q  <= '0;
            timed_out_q <= 1'b0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            to_cnt_q    <= '0;
`ifdef ADC_CAPTURE_DECIM_EN
            dec_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            timed_out_q <= timed_out_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            to_cnt_q    <= to_cnt_d;
`ifdef ADC_CAPTURE_DECIM_EN
            dec_cnt_q   <= dec_cnt_d;
`endif
        end
    end

    // Record buffer is intentionally not reset; it holds the last record until the next trigger.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= smp.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o   = rd_data_q;
    assign busy_o      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done_o      = (state_q == S_DONE);
    assign timed_out_o = timed_out_q;
    assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl with a 16-sample record and an 8-sample timeout.
module tb_adc_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       trig_mode = 1'b0;
    logic [7:0] trig_level = 8'h00;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       busy, done, timed_out;
    logic [4:0] wr_count;

    logic       rd_fire = 1'b0;
    logic       rd_fire_q = 1'b0;
    int         n_pass = 0;
    int         n_tot = 0;

    typedef struct { int addr; int exp; } rd_exp_t;
    rd_exp_t sb_q[$];

    adc_capture_ctrl_if #(.DATA_W(8)) smp ();

    adc_capture_ctrl #(.DATA_W(8), .DEPTH_LOG2(4), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .smp          (smp.slave),
        .start_i      (start),
        .abort_i      (abort),
        .trig_mode_i  (trig_mode),
        .trig_level_i (trig_level),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .busy_o       (busy),
        .done_o       (done),
        .timed_out_o  (timed_out),
        .wr_count_o   (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_fire_q <= rd_fire;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Read-back monitor: one cycle after a read is issued, pop and compare.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rd_fire_q) begin
                if (sb_q.size() == 0) begin
                    chk("rd_unexpected", int'(rd_data), -1);
                end else begin
                    e = sb_q.pop_front();
                    n_tot++;
                    if (int'(rd_data) == e.exp) n_pass++;
                    else $display("FAIL rd_data[%0d]: got 0x%0h expected 0x%0h", e.addr, rd_data, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        smp.data  = d;
        smp.valid = 1'b1;
        tick();
        smp.valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rd(input int a, input int e);
        rd_exp_t x;
        x.addr = a;
        x.exp  = e;
        rd_addr = a[3:0];
        sb_q.push_back(x);
        rd_fire = 1'b1;
        tick();
        rd_fire = 1'b0;
    endtask

    initial begin
        smp.data  = '0;
        smp.valid = 1'b0;
        #12;
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timed_out", int'(timed_out), 0);
        chk("rst_wr_count", int'(wr_count), 0);
        rst_n = 1'b1;
        tick();

        // Immediate trigger, ramp 0x10..0x1F; a start during capture is ignored.
        trig_mode = 1'b0;
        pulse_start();
        chk("imm_busy_armed", int'(busy), 1);
        chk("imm_wr_count_armed", int'(wr_count), 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) start = 1'b1;
            feed(8'(8'h10 + i));
            start = 1'b0;
            if (i == 0) chk("imm_wr_count_trig", int'(wr_count), 1);
            if (i == 8) chk("imm_start_ignored", int'(wr_count), 9);
            if (i == 14) chk("imm_busy_before_last", int'(busy), 1);
        end
        chk("imm_done", int'(done), 1);
        chk("imm_busy_done", int'(busy), 0);
        chk("imm_wr_count_full", int'(wr_count), 16);
        feed(8'hEE);
        chk("imm_wr_count_in_done", int'(wr_count), 16);
        chk("imm_timed_out", int'(timed_out), 0);
        for (int i = 0; i < 16; i++) rd(i, 'h10 + i);

        // Edge trigger at 0x80; the first sample 0x90 has no predecessor and cannot trigger.
        trig_mode  = 1'b1;
        trig_level = 8'h80;
        pulse_start();
        feed(8'h90);
        chk("edge_first_no_trig", int'(wr_count), 0);
        feed(8'h70);
        chk("edge_below_no_trig", int'(wr_count), 0);
        feed(8'h90);
        chk("edge_trig", int'(wr_count), 1);
        feed(8'h00);
        feed(8'h7F);
        feed(8'h80);
        for (int i = 0; i < 12; i++) feed(8'(i));
        chk("edge_done", int'(done), 1);
        chk("edge_timed_out", int'(timed_out), 0);
        rd(0, 'h90);
        rd(1, 'h00);
        rd(2, 'h7F);
        rd(3, 'h80);
        rd(4, 'h00);
        rd(15, 'h0B);

        // Timeout: constant 0x20 never crosses 0x80; 9th sample auto-triggers.
        pulse_start();
        chk("to_timed_out_cleared", int'(timed_out), 0);
        for (int i = 0; i < 8; i++) feed(8'h20);
        chk("to_no_trig_8", int'(wr_count), 0);
        chk("to_busy_8", int'(busy), 1);
        feed(8'h20);
        chk("to_trig_9", int'(wr_count), 1);
        for (int i = 0; i < 15; i++) feed(8'h20);
        chk("to_done", int'(done), 1);
        chk("to_timed_out", int'(timed_out), 1);
        rd(0, 'h20);

        // Abort beats a simultaneous start.
        trig_mode = 1'b0;
        pulse_start();
        chk("ab_timed_out_cleared", int'(timed_out), 0);
        for (int i = 1; i <= 5; i++) feed(8'(i));
        chk("ab_wr_count_5", int'(wr_count), 5);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_done", int'(done), 0);
        pulse_start();
        chk("ab_rearm_busy", int'(busy), 1);
        chk("ab_rearm_wr_count", int'(wr_count), 0);

        // Gapped valid with exact-level trigger (0x3F -> 0x40 at level 0x40).
        trig_mode  = 1'b1;
        trig_level = 8'h40;
        feed(8'h3F);
        for (int k = 0; k < 16; k++) begin
            smp.data = 8'hFF;
            tick();
            tick();
            feed(8'(8'h40 + k));
            if (k == 0) chk("gap_trig_equal", int'(wr_count), 1);
        end
        chk("gap_done", int'(done), 1);
        for (int i = 0; i < 16; i++) rd(i, 'h40 + i);

        // Asynchronous reset during capture.
        trig_mode = 1'b0;
        pulse_start();
        feed(8'hA0);
        feed(8'hA1);
        feed(8'hA2);
        chk("rc_wr_count_3", int'(wr_count), 3);
        rst_n = 1'b0;
        #1;
        chk("rc_rd_data", int'(rd_data), 0);
        chk("rc_busy", int'(busy), 0);
        chk("rc_done", int'(done), 0);
        chk("rc_timed_out", int'(timed_out), 0);
        chk("rc_wr_count", int'(wr_count), 0);
        #3;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5 && sb_q.size() != 0; i++) tick();
        if (sb_q.size() != 0) chk("sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Triggered acquisition controller that sits directly after the `adc` block and consumes its `data_out`/`data_valid` sample stream. On a start command it arms, waits for a level-crossing trigger or a timeout, then stores a fixed-length record of samples into an internal buffer. The record is read back through a synchronous read port for display and measurement logic.

## Interface
- `DATA_W`, 8, sample width; matches `adc` output
- `DEPTH_LOG2`, 8, log2 of record length (default 256 samples)
- `TIMEOUT`, 1024, valid samples spent in ARMED before an auto-trigger; 0 disables the timeout
- `clk`  in  1  system clock (100 MHz domain, same as `adc.clk`)
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle arm request
- `abort`  in  1  single-cycle cancel request
- `trig_mode`  in  1  0 = immediate trigger, 1 = rising-edge level trigger
- `trig_level`  in  DATA_W  trigger threshold; unsigned
- `sample_data`  in  DATA_W  from `adc.data_out`
- `sample_valid`  in  1  from `adc.data_valid`
- `rd_addr`  in  DEPTH_LOG2  buffer read address
- `rd_data`  out  DATA_W  registered `mem[rd_addr]`
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  high in DONE
- `timed_out`  out  1  last record was auto-triggered; valid while `done` is high
- `wr_count`  out  DEPTH_LOG2+1  samples stored in the current record

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. Reset state is IDLE.
- IDLE or DONE, on `start`:
  - go to ARMED
  - clear `wr_count`, `timed_out` and the previous-sample-valid flag
  - clear the timeout counter
- `start` in ARMED or CAPTURE is ignored.
- `abort` in any state returns to IDLE on the next edge. `abort` beats a simultaneous `start`.
- ARMED, `trig_mode`=0: the first valid sample triggers the record.
- ARMED, `trig_mode`=1: a valid sample triggers when `prev < trig_level` and `cur >= trig_level`.
  - `prev` is the previous valid sample seen in ARMED.
  - The first valid sample after arming can never trigger.
- Timeout: each non-triggering valid sample in ARMED increments the timeout counter. When the counter reaches TIMEOUT, the next valid sample triggers unconditionally and `timed_out` is set.
- The triggering sample is written to address 0 and the state moves to CAPTURE. `wr_count` becomes 1.
- CAPTURE: each valid sample is written to `mem[wr_count]` and `wr_count` increments.
- When `wr_count` reaches 2^DEPTH_LOG2, go to DONE. No wrap-around and no overwrite.
- Samples arriving in DONE or IDLE are ignored. The buffer holds the record until the next trigger.
- `rd_data` updates every cycle regardless of state. Contents read during CAPTURE are undefined for the bench; compare only while in DONE.
- Reset mid-capture:
  - all outputs go to reset values
  - buffer contents are unspecified (the memory is not reset)

## Timing
- Reset values: `rd_data`=0, `busy`=0, `done`=0, `timed_out`=0, `wr_count`=0.
- `start` at edge N gives `busy`=1 after edge N.
- The trigger sample at edge T gives state CAPTURE and `wr_count`=1 after edge T.
- The final sample at edge F gives `done`=1 and `busy`=0 after edge F. The sample is written on the same edge.
- Read latency is 1 cycle: `rd_addr` presented before edge R gives `rd_data` valid after edge R.
- `sample_valid` may be high on consecutive cycles. There is no backpressure, and every valid sample in CAPTURE is stored.

## Configuration
- `ADC_CAPTURE_DECIM_EN` defined:
  - adds input `decim` (4 bits)
  - in CAPTURE, only every (`decim`+1)-th valid sample after the trigger is stored; the trigger sample is always stored
  - trigger detection and timeout still use every valid sample
  - `decim`=0 is equivalent to no decimation
- Macro undefined: no `decim` port, and every valid sample in CAPTURE is stored.

## Test plan
- Immediate trigger, DEPTH_LOG2=4: `trig_mode`=0, start, feed ramp 0x10..0x1F on every cycle → `done` 16 cycles after the first sample; `mem[i]`=0x10+i; `timed_out`=0.
- Edge trigger: `trig_level`=0x80, feed 0x70, 0x90, 0x00, 0x7F, 0x80, then a ramp → record starts at 0x90; `mem[0]`=0x90; the leading 0x70 (no predecessor) does not trigger.
- Timeout: TIMEOUT=8, constant 0x20 with `trig_mode`=1 → the 9th sample triggers, `mem[0]`=0x20, `timed_out`=1 at `done`.
- Abort and start: abort at `wr_count`=5 together with start → IDLE, `busy`=0; a later start re-arms with `wr_count`=0.
- Gapped valid plus reset: `sample_valid` high every 3rd cycle → only valid samples are stored. Assert `rst_n`=0 mid-CAPTURE → all outputs 0 immediately.
- `ADC_CAPTURE_DECIM_EN` with `decim`=1, ramp 0..63 triggered at 0 → `mem[i]`=2i.
